addr_stack: RTL and testbench
=============================

Name: addr_stack

Overview:
- Parametrised program-counter / return-address stack for the core.
- The top-of-stack entry is the live PC. Lower entries hold return addresses.
- Assembles jump/call targets from two 8-bit bus bytes (low byte then high byte) and executes increment, jump, call, return and restart-vector operations.
- Adds occupancy tracking, overflow/underflow reporting and condition gating. The stack is circular, with wrap-around on overflow and underflow.

Parameters:
- ADDR_WIDTH, 14, PC/entry width in bits; legal range 9..16.
- DEPTH, 8, number of entries including the live PC; power of two, at least 2.
- PTR_WIDTH, $clog2(DEPTH), stack pointer width (derived; do not override).
- BYTE_WIDTH, 8, data bus width for target-byte loads.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- op  in  stack_op_t  operation for this cycle: NOP, INC, LD_LO, LD_HI, JMP, CAL, RET, RST_V.
- cond_ok  in  1  condition-pass; gates JMP, CAL and RET only.
- data_in  in  BYTE_WIDTH  bus byte for LD_LO/LD_HI.
- vec  in  3  restart vector number for RST_V.
- pc  out  ADDR_WIDTH  current PC, i.e. the entry at sp (combinational read).
- pc_lo  out  8  pc[7:0].
- pc_hi  out  ADDR_WIDTH-8  pc[ADDR_WIDTH-1:8].
- sp  out  PTR_WIDTH  stack pointer.
- level  out  PTR_WIDTH+1  occupied entries, 1..DEPTH.
- ovf  out  1  one-cycle pulse: CAL/RST_V overwrote the oldest entry.
- unf  out  1  one-cycle pulse: RET popped past the oldest valid entry.

Behaviour:
- Reset (async, held): all entries 0, sp=0, level=1, tmp=0, ovf=0, unf=0. As a result pc=0.
- Reset asserted mid-operation discards that operation. The first op after deassertion is taken at the next posedge.
- Every op is sampled on posedge clk. Its result is visible on pc/sp/level the cycle after (1-cycle latency). ovf/unf are registered and high for exactly the one cycle following the offending op.
- Sequencing is the controller's job; ops are sampled unconditionally every cycle.
- NOP: no state change.
- INC: entry[sp] <= pc+1 modulo 2^ADDR_WIDTH, so all-ones wraps to 0.
- LD_LO: tmp[7:0] <= data_in.
- LD_HI: tmp[ADDR_WIDTH-1:8] <= data_in[ADDR_WIDTH-9:0]; upper data_in bits are ignored.
- tmp persists until overwritten. JMP/CAL use the tmp value at the sampling edge.
- JMP (cond_ok=1): entry[sp] <= tmp.
- CAL (cond_ok=1):
  - sp <= sp+1 (mod DEPTH); entry[sp+1] <= tmp.
  - The old entry[sp] is left unchanged; the controller has already INCed it past the operand bytes.
  - If level==DEPTH: level stays DEPTH and ovf pulses. Otherwise level <= level+1.
- RET (cond_ok=1):
  - sp <= sp-1 (mod DEPTH); the popped entry is not cleared.
  - If level==1: level stays 1 and unf pulses; pc becomes whatever the wrapped entry holds. Otherwise level <= level-1.
- RST_V: unconditional push, same as CAL, but the new entry = {vec,3'b000} zero-extended. tmp is untouched. ovf rules as CAL.
- JMP/CAL/RET with cond_ok=0 behave as NOP: no change to sp, level or entries, and no ovf/unf pulse.
- cond_ok is ignored for all other ops.
- pc_lo/pc_hi are pure slices of pc.
- No other simultaneous events exist: one op per cycle by construction of the op encoding.

Decomposition:
- Shared package (internal_defines.vh): stack_op_t enum (3 bits, values listed above) and the RST_VEC_SHIFT=3 constant.
- One natural sub-module: stack_ram, a DEPTH x ADDR_WIDTH array with one synchronous write port and one combinational read port. It is addressed by sp for reads and by the computed write index for writes.
- Pointer/level logic and the tmp register live in addr_stack.

Test Plan:
- Reset, then 3x INC → pc=0x0003, sp=0, level=1. Assert rst asynchronously between clock edges → pc=0 immediately and sp=0.
- LD_LO 0x34, LD_HI 0x12, JMP cond_ok=1 → pc=0x1234. Repeat with target 0x3FFF, then INC → pc=0x0000 (wrap).
- From pc=0x0100: LD_LO 0x00, LD_HI 0x20, CAL → pc=0x2000, sp=1, level=2. Then RET → pc=0x0100, sp=0, level=1, no unf.
- 8 consecutive CALs to targets 0x10,0x20,...,0x80 from reset:
  - The 7th CAL reaches level=8 with no ovf.
  - The 8th CAL gives ovf=1 for one cycle, sp wraps to 0, level=8, pc=0x80.
- From reset, RET → unf=1 for one cycle, sp=7, level=1, pc=0.
- CAL/RET/JMP with cond_ok=0 after loading tmp=0x0ABC → pc, sp and level unchanged, no flag pulses. RST_V vec=5 with cond_ok=0 → pc=0x0028, sp incremented.

Source files
------------

// File: rtl/addr_stack_pkg.sv
// Shared types and constants for the program-counter / return-address stack.
package addr_stack_pkg;

  // One operation per cycle; the encoding is fixed by the controller.
  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpInc  = 3'd1,
    OpLdLo = 3'd2,
    OpLdHi = 3'd3,
    OpJmp  = 3'd4,
    OpCal  = 3'd5,
    OpRet  = 3'd6,
    OpRstV = 3'd7
  } stack_op_t;

  // Restart vectors sit on 8-location boundaries: target = vec << 3.
  localparam int unsigned RST_VEC_SHIFT = 3;

  // True for the ops that only take effect when the condition passes.
  function automatic logic op_is_conditional(stack_op_t op);
    return (op == OpJmp) || (op == OpCal) || (op == OpRet);
  endfunction

endpackage

// File: rtl/addr_stack_ram.sv
// DEPTH x ADDR_WIDTH entry array: one synchronous write port, one
// combinational read port. All entries clear on reset.
module addr_stack_ram #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [PTR_WIDTH-1:0]  waddr_i,
  input  logic [ADDR_WIDTH-1:0] wdata_i,
  input  logic [PTR_WIDTH-1:0]  raddr_i,
  output logic [ADDR_WIDTH-1:0] rdata_o
);

  logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_d [DEPTH];

  // Next-state of the array: only the addressed entry changes on a write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  // Entry storage with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/addr_stack.sv
// Program-counter / return-address stack. The entry at sp is the live PC;
// entries below it hold return addresses. The stack is circular: pushes past
// DEPTH overwrite the oldest entry (ovf), pops past the bottom wrap (unf).
module addr_stack
  import addr_stack_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH),
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  stack_op_t             op,
  input  logic                  cond_ok,
  input  logic [BYTE_WIDTH-1:0] data_in,
  input  logic [2:0]            vec,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [7:0]            pc_lo,
  output logic [ADDR_WIDTH-9:0] pc_hi,
  output logic [PTR_WIDTH-1:0]  sp,
  output logic [PTR_WIDTH:0]    level,
  output logic                  ovf,
  output logic                  unf
);

  localparam int unsigned LvlWidth = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] LvlFull = LvlWidth'(DEPTH);
  localparam logic [PTR_WIDTH:0] LvlOne  = LvlWidth'(1);

  logic [PTR_WIDTH-1:0]  sp_q, sp_d;
  logic [PTR_WIDTH:0]    level_q, level_d;
  logic [ADDR_WIDTH-1:0] tmp_q, tmp_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  ram_we;
  logic [PTR_WIDTH-1:0]  ram_waddr;
  logic [ADDR_WIDTH-1:0] ram_wdata;
  logic [ADDR_WIDTH-1:0] ram_rdata;

  logic                  push;
  logic [ADDR_WIDTH-1:0] push_val;
  logic                  take;
  logic [PTR_WIDTH-1:0]  sp_inc;
  logic [PTR_WIDTH-1:0]  sp_dec;

  assign sp_inc = sp_q + PTR_WIDTH'(1);
  assign sp_dec = sp_q - PTR_WIDTH'(1);
  // Conditional ops with a failed condition degrade to NOP.
  assign take   = !op_is_conditional(op) || cond_ok;

  // Decode the op into entry writes, pointer/level moves and flag pulses.
  always_comb begin
    sp_d      = sp_q;
    level_d   = level_q;
    tmp_d     = tmp_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = sp_q;
    ram_wdata = ram_rdata;
    push      = 1'b0;
    push_val  = '0;

    unique case (op)
      OpNop: begin
      end
      OpInc: begin
        ram_we    = 1'b1;
        ram_wdata = ram_rdata + ADDR_WIDTH'(1);
      end
      OpLdLo: begin
        tmp_d[7:0] = data_in[7:0];
      end
      OpLdHi: begin
        // Only the bits that fit above the low byte are kept.
        tmp_d[ADDR_WIDTH-1:8] = data_in[ADDR_WIDTH-9:0];
      end
      OpJmp: begin
        if (take) begin
          ram_we    = 1'b1;
          ram_wdata = tmp_q;
        end
      end
      OpCal: begin
        if (take) begin
          push     = 1'b1;
          push_val = tmp_q;
        end
      end
      OpRet: begin
        if (take) begin
          sp_d = sp_dec;
          if (level_q == LvlOne) begin
            unf_d = 1'b1;
          end else begin
            level_d = level_q - LvlOne;
          end
        end
      end
      OpRstV: begin
        push     = 1'b1;
        push_val = ADDR_WIDTH'({vec, {RST_VEC_SHIFT{1'b0}}});
      end
      default: begin
      end
    endcase

    // Push: new entry goes above the live PC, which is left as-is.
    if (push) begin
      sp_d      = sp_inc;
      ram_we    = 1'b1;
      ram_waddr = sp_inc;
      ram_wdata = push_val;
      if (level_q == LvlFull) begin
        ovf_d = 1'b1;
      end else begin
        level_d = level_q + LvlOne;
      end
    end
  end

  // Pointer, occupancy, target assembly register and flag pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q    <= '0;
      level_q <= LvlOne;
      tmp_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      level_q <= level_d;
      tmp_q   <= tmp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  addr_stack_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (sp_q),
    .rdata_o (ram_rdata)
  );

  assign pc    = ram_rdata;
  assign pc_lo = ram_rdata[7:0];
  assign pc_hi = ram_rdata[ADDR_WIDTH-1:8];
  assign sp    = sp_q;
  assign level = level_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_addr_stack.sv
// Self-checking bench for addr_stack: directed table, hand-written corner
// sequences and randomized ops against a behavioural stack model.
module tb_addr_stack;
  import addr_stack_pkg::*;

  localparam int AW    = 14;
  localparam int DEPTH = 8;
  localparam int PW    = 3;

  logic            clk;
  logic            rst;
  stack_op_t       op;
  logic            cond_ok;
  logic [7:0]      data_in;
  logic [2:0]      vec;
  logic [AW-1:0]   pc;
  logic [7:0]      pc_lo;
  logic [AW-9:0]   pc_hi;
  logic [PW-1:0]   sp;
  logic [PW:0]     level;
  logic            ovf;
  logic            unf;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  int m_mem [DEPTH];
  int m_sp, m_level, m_tmp, m_ovf, m_unf;

  addr_stack #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .BYTE_WIDTH (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .op      (op),
    .cond_ok (cond_ok),
    .data_in (data_in),
    .vec     (vec),
    .pc      (pc),
    .pc_lo   (pc_lo),
    .pc_hi   (pc_hi),
    .sp      (sp),
    .level   (level),
    .ovf     (ovf),
    .unf     (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    stack_op_t  op;
    logic       c;
    logic [7:0] d;
    logic [2:0] v;
    int         pc;
    int         sp;
    int         lvl;
    int         ovf;
    int         unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(stack_op_t o, logic c, logic [7:0] d, logic [2:0] v,
                              int p, int s, int l, int ov, int un);
    vec_t r;
    r.op = o; r.c = c; r.d = d; r.v = v;
    r.pc = p; r.sp = s; r.lvl = l; r.ovf = ov; r.unf = un;
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_sp = 0; m_level = 1; m_tmp = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_push(int val);
    m_sp = (m_sp + 1) % DEPTH;
    m_mem[m_sp] = val;
    if (m_level == DEPTH) m_ovf = 1;
    else m_level = m_level + 1;
  endtask

  task automatic model_step(stack_op_t o, logic c, logic [7:0] d, logic [2:0] v);
    m_ovf = 0;
    m_unf = 0;
    case (o)
      OpInc:  m_mem[m_sp] = (m_mem[m_sp] + 1) % (1 << AW);
      OpLdLo: m_tmp = (m_tmp & ~32'hFF) | int'(d);
      OpLdHi: m_tmp = (m_tmp & 32'hFF) | ((int'(d) % (1 << (AW - 8))) * 256);
      OpJmp:  if (c) m_mem[m_sp] = m_tmp;
      OpCal:  if (c) model_push(m_tmp);
      OpRet: begin
        if (c) begin
          m_sp = (m_sp + DEPTH - 1) % DEPTH;
          if (m_level == 1) m_unf = 1;
          else m_level = m_level - 1;
        end
      end
      OpRstV: model_push(int'(v) * 8);
      default: ;
    endcase
  endtask

  task automatic check_model();
    chk("model_pc", int'(pc), m_mem[m_sp]);
    chk("model_sp", int'(sp), m_sp);
    chk("model_level", int'(level), m_level);
    chk("model_ovf", int'(ovf), m_ovf);
    chk("model_unf", int'(unf), m_unf);
    chk("pc_slices", int'({pc_hi, pc_lo}), m_mem[m_sp]);
  endtask

  // Called just after a negedge; drives one op and checks at the next negedge.
  task automatic apply(stack_op_t o, logic c, logic [7:0] d, logic [2:0] v);
    op = o; cond_ok = c; data_in = d; vec = v;
    @(negedge clk);
    model_step(o, c, d, v);
    check_model();
  endtask

  // Asserts reset between edges with an INC pending; that INC must be lost.
  task automatic async_reset();
    op = OpInc; cond_ok = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc", int'(pc), 0);
    chk("async_rst_sp", int'(sp), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_held_pc", int'(pc), 0);
    chk("rst_held_level", int'(level), 1);
  endtask

  initial begin
    rst = 1'b1; op = OpNop; cond_ok = 1'b0; data_in = '0; vec = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_pc", int'(pc), 0);
    chk("reset_sp", int'(sp), 0);
    chk("reset_level", int'(level), 1);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_unf", int'(unf), 0);

    // 3x INC then async reset mid-cycle.
    for (int i = 1; i <= 3; i++) apply(OpInc, 1'b0, 8'h00, 3'd0);
    chk("inc3_pc", int'(pc), 3);
    async_reset();

    // Directed table from reset state.
    tbl.push_back(mk(OpInc,  1, 8'h00, 0, 16'h0001, 0, 1, 0, 0));
    tbl.push_back(mk(OpLdLo, 0, 8'h34, 0, 16'h0001, 0, 1, 0, 0));
    tbl.push_back(mk(OpLdHi, 0, 8'h12, 0, 16'h0001, 0, 1, 0, 0));
    tbl.push_back(mk(OpJmp,  1, 8'h00, 0, 16'h1234, 0, 1, 0, 0));
    tbl.push_back(mk(OpLdLo, 0, 8'hFF, 0, 16'h1234, 0, 1, 0, 0));
    tbl.push_back(mk(OpLdHi, 0, 8'hFF, 0, 16'h1234, 0, 1, 0, 0));
    tbl.push_back(mk(OpJmp,  1, 8'h00, 0, 16'h3FFF, 0, 1, 0, 0));
    tbl.push_back(mk(OpInc,  0, 8'h00, 0, 16'h0000, 0, 1, 0, 0));
    tbl.push_back(mk(OpLdLo, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 0));
    tbl.push_back(mk(OpLdHi, 0, 8'h01, 0, 16'h0000, 0, 1, 0, 0));
    tbl.push_back(mk(OpJmp,  1, 8'h00, 0, 16'h0100, 0, 1, 0, 0));
    tbl.push_back(mk(OpLdHi, 0, 8'h20, 0, 16'h0100, 0, 1, 0, 0));
    tbl.push_back(mk(OpCal,  1, 8'h00, 0, 16'h2000, 1, 2, 0, 0));
    tbl.push_back(mk(OpRet,  1, 8'h00, 0, 16'h0100, 0, 1, 0, 0));
    tbl.push_back(mk(OpRet,  1, 8'h00, 0, 16'h0000, 7, 1, 0, 1));
    tbl.push_back(mk(OpNop,  1, 8'h00, 0, 16'h0000, 7, 1, 0, 0));
    tbl.push_back(mk(OpLdLo, 0, 8'hBC, 0, 16'h0000, 7, 1, 0, 0));
    tbl.push_back(mk(OpLdHi, 0, 8'h0A, 0, 16'h0000, 7, 1, 0, 0));
    tbl.push_back(mk(OpCal,  0, 8'h00, 0, 16'h0000, 7, 1, 0, 0));
    tbl.push_back(mk(OpRet,  0, 8'h00, 0, 16'h0000, 7, 1, 0, 0));
    tbl.push_back(mk(OpJmp,  0, 8'h00, 0, 16'h0000, 7, 1, 0, 0));
    tbl.push_back(mk(OpRstV, 0, 8'h00, 5, 16'h0028, 0, 2, 0, 0));
    tbl.push_back(mk(OpJmp,  1, 8'h00, 0, 16'h0ABC, 0, 2, 0, 0));

    foreach (tbl[i]) begin
      apply(tbl[i].op, tbl[i].c, tbl[i].d, tbl[i].v);
      chk($sformatf("tbl%0d_pc", i), int'(pc), tbl[i].pc);
      chk($sformatf("tbl%0d_sp", i), int'(sp), tbl[i].sp);
      chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].lvl);
      chk($sformatf("tbl%0d_ovf", i), int'(ovf), tbl[i].ovf);
      chk($sformatf("tbl%0d_unf", i), int'(unf), tbl[i].unf);
    end

    // Eight calls from reset: the eighth overflows and wraps sp to 0.
    async_reset();
    for (int i = 1; i <= 8; i++) begin
      apply(OpLdLo, 1'b0, 8'(i * 16), 3'd0);
      apply(OpLdHi, 1'b0, 8'h00, 3'd0);
      apply(OpCal, 1'b1, 8'h00, 3'd0);
      chk($sformatf("cal%0d_pc", i), int'(pc), i * 16);
      chk($sformatf("cal%0d_sp", i), int'(sp), i % 8);
      chk($sformatf("cal%0d_level", i), int'(level), (i + 1 > 8) ? 8 : i + 1);
      chk($sformatf("cal%0d_ovf", i), int'(ovf), (i == 8) ? 1 : 0);
    end
    apply(OpNop, 1'b0, 8'h00, 3'd0);
    chk("ovf_one_cycle", int'(ovf), 0);
    chk("ovf_level_hold", int'(level), 8);

    // Randomized ops against the model.
    async_reset();
    for (int n = 0; n < 600; n++) begin
      apply(stack_op_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            8'($urandom), 3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
